mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares the single 8-bit synchronous memory port (20-bit address, 8-bit read/write data, write enable) between two requesters, port 0 (CPU core) and port 1 (DMA/video fetch).
Each requester issues byte or 16-bit word reads/writes over a req/ack handshake. The arbiter splits each word into two little-endian byte cycles (low byte at addr, high byte at addr+1) and returns assembled read data.
It sits between the core/peripherals and the memory block.

Parameters:
ADDR_W, 20, width of address buses.
PRIO_FIXED, 0, 0 = round-robin between ports; 1 = port 0 always wins simultaneous requests.

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
m0_req  in  1  port 0 transfer request, held until ack
m0_we  in  1  port 0: 1 = write, 0 = read
m0_word  in  1  port 0: 1 = 16-bit, 0 = 8-bit
m0_addr  in  ADDR_W  port 0 byte address
m0_wdata  in  16  port 0 write data (byte transfers use [7:0])
m0_rdata  out  16  port 0 read data, valid while m0_ack=1
m0_ack  out  1  port 0 one-cycle completion pulse
m1_req, m1_we, m1_word, m1_addr, m1_wdata, m1_rdata, m1_ack: same as port 0, for port 1
address  out  ADDR_W  memory address
data  in  8  memory read data; valid one cycle after address presented
out  out  8  memory write data
wren  out  1  memory write enable, write occurs at rising edge while high

Behaviour:
- All outputs registered. Reset values: address=0, out=0, wren=0, m0_ack=m1_ack=0, m0_rdata=m1_rdata=0, state=IDLE, round-robin pointer set so port 0 wins first.
- States: IDLE, LO, HI, FIN, ACK.
- IDLE, sampled at edge E0:
  - If any req is high, grant one port and latch its we/word/addr/wdata.
  - Drive address=addr; if we, set out=wdata[7:0] and wren=1. Go to LO.
  - If no req, stay in IDLE with wren=0.
- LO (low byte on bus), at edge E1:
  - If word: address=addr+1 (wraps modulo 2^ADDR_W, so 0xFFFFF -> 0x00000), out=wdata[15:8], wren=we. Go to HI.
  - If byte: wren=0. Go to FIN.
- HI, at edge E2: capture data into rdata[7:0] (low byte, read only); wren=0. Go to FIN.
- FIN, at the next edge:
  - Byte read: rdata={8'h00, data}.
  - Word read: rdata[15:8]=data.
  - Assert the granted port's ack. Go to ACK.
- ACK: ack=1 for exactly this cycle, with rdata valid. At the next edge, clear ack and go to IDLE without sampling requests.
- Latency from request-sampling edge to ack high: byte 2 cycles, word 3 cycles, for both reads and writes.
- Writes leave rdata unchanged.
- Back-to-back:
  - A requester drops req at the edge where it samples ack=1; req high in the following cycle means a new transaction.
  - Minimum issue interval: byte 4 cycles, word 5 cycles.
  - The non-granted port's req is held pending and is never acked spuriously.
- Arbitration, applied only in IDLE:
  - PRIO_FIXED=0: on simultaneous requests, grant the port not granted last. A lone requester is always granted.
  - PRIO_FIXED=1: port 0 wins every tie.
- Requester inputs may change while not granted. The latched copy is used during a transfer, so a granted port changing inputs mid-transfer does not affect the bus.
- Reset mid-transfer: state returns to IDLE next cycle, wren=0 immediately, no ack issued, and the transfer is dropped. A memory write already clocked is not undone.
- Only one ack is high in any cycle. Both acks are 0 outside ACK.

Test Plan:
1. Port 0 byte read at 0x00010, memory[0x10]=0x5A -> address=0x00010 after E0; m0_ack high at E0+2 with m0_rdata=0x005A; wren stays 0.
2. Port 1 word write 0x1234 to 0x00200 -> bus writes 0x34 at 0x00200 then 0x12 at 0x00201, one cycle each; m1_ack at E0+3; a readback word gives 0x1234.
3. Word read at 0xFFFFF with mem[0xFFFFF]=0xCD, mem[0x00000]=0xAB -> second address=0x00000; m0_rdata=0xABCD.
4. Both ports hold byte reads continuously, PRIO_FIXED=0 -> grants alternate 0,1,0,1; each ack has the correct data; no cycle has both acks. With PRIO_FIXED=1 -> port 0 served every time while its req stays high.
5. Reset asserted while in HI of a word write -> wren=0 the next cycle, state IDLE, no ack; the following request completes normally.
6. Port 0 keeps req high after ack with new addr/data -> new transaction starts at the ACK->IDLE+1 edge; no duplicate transfer of the old request.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter for a single 8-bit synchronous memory port.
// Word transfers are split into two little-endian byte cycles; read data is reassembled.
module mem_arbiter #(
   parameter int unsigned ADDR_W     = 20,
   parameter int unsigned PRIO_FIXED = 0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic              m0_word,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [15:0]       m0_wdata,
   output logic [15:0]       m0_rdata,
   output logic              m0_ack,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic              m1_word,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [15:0]       m1_wdata,
   output logic [15:0]       m1_rdata,
   output logic              m1_ack,
   output logic [ADDR_W-1:0] address,
   input  logic [7:0]        data,
   output logic [7:0]        out,
   output logic              wren
);

   localparam logic [2:0] StIdle = 3'd0;
   localparam logic [2:0] StLo   = 3'd1;
   localparam logic [2:0] StHi   = 3'd2;
   localparam logic [2:0] StFin  = 3'd3;
   localparam logic [2:0] StAck  = 3'd4;

   logic [2:0]        state_q, state_d;
   logic              gnt_q, gnt_d;
   logic              last_q, last_d;
   logic              we_q, we_d;
   logic              word_q, word_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       wdata_q, wdata_d;
   logic [ADDR_W-1:0] address_q, address_d;
   logic [7:0]        out_q, out_d;
   logic              wren_q, wren_d;
   logic              ack0_q, ack0_d;
   logic              ack1_q, ack1_d;
   logic [15:0]       rdata0_q, rdata0_d;
   logic [15:0]       rdata1_q, rdata1_d;

   logic              sel;
   logic [15:0]       rd_cur;
   logic [15:0]       rd_new;

   // Port 1 wins when alone, or on a tie in round-robin mode if port 0 was served last.
   assign sel    = m1_req & (~m0_req | ((PRIO_FIXED == 0) & ~last_q));
   assign rd_cur = gnt_q ? rdata1_q : rdata0_q;

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      last_d    = last_q;
      we_d      = we_q;
      word_d    = word_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      address_d = address_q;
      out_d     = out_q;
      wren_d    = wren_q;
      ack0_d    = 1'b0;
      ack1_d    = 1'b0;
      rd_new    = rd_cur;

      case (state_q)
         StIdle: begin
            wren_d = 1'b0;
            if (m0_req || m1_req) begin
               gnt_d     = sel;
               last_d    = sel;
               we_d      = sel ? m1_we : m0_we;
               word_d    = sel ? m1_word : m0_word;
               addr_d    = sel ? m1_addr : m0_addr;
               wdata_d   = sel ? m1_wdata : m0_wdata;
               address_d = sel ? m1_addr : m0_addr;
               if (sel ? m1_we : m0_we) begin
                  out_d  = sel ? m1_wdata[7:0] : m0_wdata[7:0];
                  wren_d = 1'b1;
               end
               state_d = StLo;
            end
         end
         StLo: begin
            if (word_q) begin
               address_d = addr_q + ADDR_W'(1);
               out_d     = wdata_q[15:8];
               wren_d    = we_q;
               state_d   = StHi;
            end else begin
               wren_d  = 1'b0;
               state_d = StFin;
            end
         end
         StHi: begin
            if (!we_q) rd_new[7:0] = data;
            wren_d  = 1'b0;
            state_d = StFin;
         end
         StFin: begin
            if (!we_q) begin
               if (word_q) rd_new[15:8] = data;
               else        rd_new = {8'h00, data};
            end
            ack0_d  = ~gnt_q;
            ack1_d  = gnt_q;
            state_d = StAck;
         end
         StAck: begin
            state_d = StIdle;
         end
         default: begin
            wren_d  = 1'b0;
            state_d = StIdle;
         end
      endcase

      rdata0_d = gnt_q ? rdata0_q : rd_new;
      rdata1_d = gnt_q ? rd_new : rdata1_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= StIdle;
         gnt_q     <= 1'b0;
         last_q    <= 1'b1;
         we_q      <= 1'b0;
         word_q    <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         address_q <= '0;
         out_q     <= '0;
         wren_q    <= 1'b0;
         ack0_q    <= 1'b0;
         ack1_q    <= 1'b0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         last_q    <= last_d;
         we_q      <= we_d;
         word_q    <= word_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         address_q <= address_d;
         out_q     <= out_d;
         wren_q    <= wren_d;
         ack0_q    <= ack0_d;
         ack1_q    <= ack1_d;
         rdata0_q  <= rdata0_d;
         rdata1_q  <= rdata1_d;
      end
   end

   assign address  = address_q;
   assign out      = out_q;
   assign wren     = wren_q;
   assign m0_ack   = ack0_q;
   assign m1_ack   = ack1_q;
   assign m0_rdata = rdata0_q;
   assign m1_rdata = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: round-robin instance on a modelled memory, plus a fixed-priority
// instance on a read-only pattern memory. Expectations come from a transaction-level model.
module tb_mem_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b1;

   logic        m0_req = 1'b0, m0_we = 1'b0, m0_word = 1'b0;
   logic [19:0] m0_addr = '0;
   logic [15:0] m0_wdata = '0;
   logic [15:0] m0_rdata;
   logic        m0_ack;
   logic        m1_req = 1'b0, m1_we = 1'b0, m1_word = 1'b0;
   logic [19:0] m1_addr = '0;
   logic [15:0] m1_wdata = '0;
   logic [15:0] m1_rdata;
   logic        m1_ack;
   logic [19:0] address;
   logic [7:0]  data = '0;
   logic [7:0]  out;
   logic        wren;

   logic        f0_req = 1'b0, f1_req = 1'b0;
   logic [19:0] f0_addr = '0, f1_addr = '0;
   logic [15:0] f0_rdata, f1_rdata;
   logic        f0_ack, f1_ack;
   logic [19:0] f_address;
   logic [7:0]  f_data = '0;
   logic [7:0]  f_out;
   logic        f_wren;

   int          checks = 0;
   int          errors = 0;

   logic [7:0]  mem_w [logic [19:0]];
   logic [7:0]  ref_w [logic [19:0]];
   logic [27:0] wlog [$];
   logic [15:0] exp_rd [2];
   bit          rr_last = 1'b1;

   mem_arbiter #(.ADDR_W(20), .PRIO_FIXED(0)) u_rr (
      .clock(clock), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_word(m0_word), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ack(m0_ack),
      .m1_req(m1_req), .m1_we(m1_we), .m1_word(m1_word), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ack(m1_ack),
      .address(address), .data(data), .out(out), .wren(wren)
   );

   mem_arbiter #(.ADDR_W(20), .PRIO_FIXED(1)) u_fx (
      .clock(clock), .reset(reset),
      .m0_req(f0_req), .m0_we(1'b0), .m0_word(1'b0), .m0_addr(f0_addr),
      .m0_wdata(16'h0000), .m0_rdata(f0_rdata), .m0_ack(f0_ack),
      .m1_req(f1_req), .m1_we(1'b0), .m1_word(1'b0), .m1_addr(f1_addr),
      .m1_wdata(16'h0000), .m1_rdata(f1_rdata), .m1_ack(f1_ack),
      .address(f_address), .data(f_data), .out(f_out), .wren(f_wren)
   );

   always #5 clock = ~clock;

   function automatic logic [7:0] init_pat(input logic [19:0] a);
      return a[7:0] ^ a[15:8] ^ {4'h5, a[19:16]};
   endfunction

   function automatic logic [7:0] ref_rd(input logic [19:0] a);
      return ref_w.exists(a) ? ref_w[a] : init_pat(a);
   endfunction

   // Synchronous memory: read data appears one cycle after the address.
   always @(posedge clock) begin
      data <= mem_w.exists(address) ? mem_w[address] : init_pat(address);
      if (wren) begin
         mem_w[address] = out;
         wlog.push_back({address, out});
      end
   end

   always @(posedge clock) f_data <= f_address[7:0] ^ 8'h3C;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clock) begin
      if (!reset) begin
         chk("dual_ack_rr", 32'(m0_ack & m1_ack), 0);
         chk("dual_ack_fx", 32'(f0_ack & f1_ack), 0);
      end
   end

   task automatic drive(input bit p, input bit req, input bit we, input bit word,
                        input logic [19:0] a, input logic [15:0] wd);
      if (p) begin
         m1_req = req; m1_we = we; m1_word = word; m1_addr = a; m1_wdata = wd;
      end else begin
         m0_req = req; m0_we = we; m0_word = word; m0_addr = a; m0_wdata = wd;
      end
   endtask

   task automatic xfer(input bit p, input bit we, input bit word, input logic [19:0] a,
                       input logic [15:0] wd);
      logic [19:0] a1;
      int          cyc;
      bit          got;
      a1 = a + 20'd1;
      @(posedge clock); #1;
      wlog.delete();
      drive(p, 1'b1, we, word, a, wd);
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 20) begin
         @(posedge clock); #1;
         cyc++;
         if (cyc == 1) begin
            chk("grant_addr", address, a);
            chk("grant_wren", wren, we);
            if (we) chk("grant_out", out, wd[7:0]);
            // Inputs change mid-transfer; the latched request must be used.
            drive(p, 1'b1, 1'($urandom), 1'($urandom), 20'($urandom), 16'($urandom));
         end
         got = p ? m1_ack : m0_ack;
         chk("other_ack", p ? m0_ack : m1_ack, 0);
      end
      chk("latency", cyc - 1, word ? 3 : 2);
      if (we) begin
         ref_w[a] = wd[7:0];
         if (word) ref_w[a1] = wd[15:8];
         chk("wr_count", wlog.size(), word ? 2 : 1);
         if (wlog.size() >= 1) chk("wr_lo", wlog[0], {a, wd[7:0]});
         if (word && wlog.size() >= 2) chk("wr_hi", wlog[1], {a1, wd[15:8]});
      end else begin
         chk("rd_nowrite", wlog.size(), 0);
         exp_rd[p] = word ? {ref_rd(a1), ref_rd(a)} : {8'h00, ref_rd(a)};
      end
      chk("rdata", p ? m1_rdata : m0_rdata, exp_rd[p]);
      drive(p, 1'b0, 1'b0, 1'b0, '0, '0);
      rr_last = p;
   endtask

   // Requests held continuously; a new address is presented each time an ack is seen.
   task automatic stream(input bit use0, input bit use1, input int n);
      logic [19:0] cur [2];
      int          cyc, prev, served;
      bit          p, expp;
      @(posedge clock); #1;
      cur[0] = 20'h00400 | 20'($urandom_range(0, 255));
      cur[1] = 20'h00400 | 20'($urandom_range(0, 255));
      if (use0) drive(1'b0, 1'b1, 1'b0, 1'b0, cur[0], '0);
      if (use1) drive(1'b1, 1'b1, 1'b0, 1'b0, cur[1], '0);
      cyc = 0;
      prev = 0;
      served = 0;
      while (served < n && cyc < 8 * n + 8) begin
         @(posedge clock); #1;
         cyc++;
         if (m0_ack || m1_ack) begin
            p = m1_ack;
            expp = (use0 && use1) ? ~rr_last : use1;
            chk("stream_port", p, expp);
            exp_rd[p] = {8'h00, ref_rd(cur[p])};
            chk("stream_rdata", p ? m1_rdata : m0_rdata, exp_rd[p]);
            chk("stream_gap", cyc - prev, served == 0 ? 3 : 4);
            prev = cyc;
            rr_last = p;
            served++;
            cur[p] = 20'h00400 | 20'($urandom_range(0, 255));
            drive(p, 1'b1, 1'b0, 1'b0, cur[p], '0);
         end
      end
      chk("stream_count", served, n);
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   initial begin
      logic [19:0] fa0, fa1;
      int          cyc, served0;
      bit          got;

      exp_rd[0] = '0;
      exp_rd[1] = '0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_address", address, 0);
      chk("rst_out", out, 0);
      chk("rst_wren", wren, 0);
      chk("rst_ack0", m0_ack, 0);
      chk("rst_ack1", m1_ack, 0);
      chk("rst_rdata0", m0_rdata, 0);
      chk("rst_rdata1", m1_rdata, 0);
      reset = 1'b0;

      xfer(1'b0, 1'b1, 1'b0, 20'h00010, 16'h005A);
      xfer(1'b0, 1'b0, 1'b0, 20'h00010, 16'h0000);
      chk("t1_rdata", m0_rdata, 16'h005A);
      xfer(1'b1, 1'b1, 1'b1, 20'h00200, 16'h1234);
      xfer(1'b1, 1'b0, 1'b1, 20'h00200, 16'h0000);
      chk("t2_rdata", m1_rdata, 16'h1234);
      xfer(1'b0, 1'b1, 1'b0, 20'hFFFFF, 16'h00CD);
      xfer(1'b1, 1'b1, 1'b0, 20'h00000, 16'h00AB);
      xfer(1'b0, 1'b0, 1'b1, 20'hFFFFF, 16'h0000);
      chk("t3_rdata", m0_rdata, 16'hABCD);

      for (int i = 0; i < 12; i++) begin
         xfer(1'($urandom), 1'($urandom), 1'($urandom),
              20'h00400 | 20'($urandom_range(0, 63)), 16'($urandom));
      end

      stream(1'b1, 1'b0, 3);
      stream(1'b1, 1'b1, 6);

      // Fixed priority: port 0 keeps winning while its request stays high.
      @(posedge clock); #1;
      fa0 = 20'($urandom);
      fa1 = 20'($urandom);
      f0_addr = fa0;
      f1_addr = fa1;
      f0_req = 1'b1;
      f1_req = 1'b1;
      cyc = 0;
      served0 = 0;
      while (served0 < 4 && cyc < 40) begin
         @(posedge clock); #1;
         cyc++;
         if (f0_ack || f1_ack) begin
            chk("fix_port", f1_ack, 0);
            chk("fix_rdata", f0_rdata, {8'h00, fa0[7:0] ^ 8'h3C});
            served0++;
            fa0 = 20'($urandom);
            f0_addr = fa0;
         end
      end
      chk("fix_count", served0, 4);
      f0_req = 1'b0;
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 20) begin
         @(posedge clock); #1;
         cyc++;
         got = f1_ack;
      end
      chk("fix_p1_lat", cyc, 4);
      chk("fix_p1_rdata", f1_rdata, {8'h00, fa1[7:0] ^ 8'h3C});
      f1_req = 1'b0;

      // Reset while the high byte of a word write is on the bus.
      @(posedge clock); #1;
      @(posedge clock); #1;
      drive(1'b1, 1'b1, 1'b1, 1'b1, 20'h00300, 16'hBEEF);
      @(posedge clock); #1;
      chk("rst5_lo_wren", wren, 1);
      @(posedge clock); #1;
      chk("rst5_hi_wren", wren, 1);
      chk("rst5_hi_addr", address, 20'h00301);
      reset = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      @(posedge clock); #1;
      chk("rst5_wren", wren, 0);
      chk("rst5_address", address, 0);
      reset = 1'b0;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      rr_last = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clock); #1;
         chk("rst5_noack", 32'(m0_ack | m1_ack), 0);
      end
      xfer(1'b1, 1'b0, 1'b1, 20'h00200, 16'h0000);
      chk("rst5_after", m1_rdata, 16'h1234);
      stream(1'b1, 1'b1, 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
